// File: rtl/msf_envelope_slicer_if.sv
// Averaged-amplitude stream from the IQ averager into the MSF envelope slicer.
interface msf_envelope_slicer_if;
   logic [15:0] average;
   logic        valid;

   modport master (output average, output valid);
   modport slave  (input  average, input  valid);
endinterface

// File: rtl/msf_envelope_slicer.sv
// Carrier envelope tracker, hysteresis slicer and MSF second decoder producing
// bit A, bit B and the minute marker once per second.
module msf_envelope_slicer #(
   parameter int AVG_PER_100MS = 10,
   parameter int DECAY_SHIFT   = 8,
   parameter int HYST          = 32,
   parameter int MIN_SPAN      = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   msf_envelope_slicer_if.slave stream,
   output logic                 carrier_on,
   output logic [15:0]          threshold,
   output logic                 locked,
   output logic                 sec_strobe,
   output logic                 bit_a,
   output logic                 bit_b,
   output logic                 minute_marker,
   output logic                 lost_sync
);

   localparam int N = AVG_PER_100MS;
   localparam logic [9:0] CNT_A    = 10'(3 * N / 2);
   localparam logic [9:0] CNT_B    = 10'(5 * N / 2);
   localparam logic [9:0] CNT_M    = 10'(9 * N / 2);
   localparam logic [9:0] CNT_SEC  = 10'(5 * N);
   localparam logic [9:0] CNT_MIN  = 10'(9 * N);
   localparam logic [9:0] CNT_LOST = 10'(12 * N);

   typedef enum logic [1:0] {HUNT, MEASURE, WAIT_EDGE} state_t;

   state_t      state;
   logic [15:0] peak;
   logic [15:0] env_floor;
   logic [9:0]  count;
   logic        samp_a;
   logic        samp_b;
   logic        samp_m;

   logic [16:0] span;
   logic [15:0] thr_next;
   logic        lock_next;
   logic [16:0] hi_sum;
   logic [15:0] hi_lvl;
   logic [15:0] lo_lvl;
   logic        carrier_next;
   logic        fall;
   logic [15:0] peak_next;
   logic [15:0] floor_next;
   logic [9:0]  count_inc;

   // Slicer decisions are taken against the envelope as it stood before this sample.
   always_comb begin
      span         = (peak > env_floor) ? ({1'b0, peak} - {1'b0, env_floor}) : 17'd0;
      thr_next     = env_floor + span[16:1];
      lock_next    = (span >= 17'(MIN_SPAN));
      hi_sum       = {1'b0, thr_next} + 17'(HYST);
      hi_lvl       = hi_sum[16] ? 16'hFFFF : hi_sum[15:0];
      lo_lvl       = ({1'b0, thr_next} >= 17'(HYST)) ? (thr_next - 16'(HYST)) : 16'd0;
      carrier_next = carrier_on;
      if (!lock_next)
         carrier_next = 1'b0;
      else if (stream.average > hi_lvl)
         carrier_next = 1'b1;
      else if (stream.average < lo_lvl)
         carrier_next = 1'b0;
      fall         = carrier_on & ~carrier_next;
      peak_next    = (stream.average > peak) ? stream.average : (peak - (peak >> DECAY_SHIFT));
      floor_next   = env_floor;
      if (stream.average < env_floor)
         floor_next = stream.average;
      else if (peak > env_floor)
         floor_next = env_floor + 16'(span >> DECAY_SHIFT);
      count_inc    = (count == 10'h3FF) ? count : (count + 10'd1);
   end

   // Envelope registers and the second-phase FSM, both advanced only by valid samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= HUNT;
         peak          <= 16'd0;
         env_floor     <= 16'hFFFF;
         threshold     <= 16'd0;
         carrier_on    <= 1'b0;
         locked        <= 1'b0;
         count         <= 10'd0;
         samp_a        <= 1'b0;
         samp_b        <= 1'b0;
         samp_m        <= 1'b0;
         sec_strobe    <= 1'b0;
         bit_a         <= 1'b0;
         bit_b         <= 1'b0;
         minute_marker <= 1'b0;
         lost_sync     <= 1'b0;
      end else begin
         sec_strobe <= 1'b0;
         lost_sync  <= 1'b0;
         if (stream.valid) begin
            peak       <= peak_next;
            env_floor  <= floor_next;
            threshold  <= thr_next;
            locked     <= lock_next;
            carrier_on <= carrier_next;
            count      <= count_inc;
            if (!lock_next) begin
               state <= HUNT;
            end else begin
               case (state)
                  HUNT: begin
                     if (fall) begin
                        count <= 10'd0;
                        state <= MEASURE;
                     end
                  end
                  MEASURE: begin
                     if (count == CNT_A) samp_a <= ~carrier_on;
                     if (count == CNT_B) samp_b <= ~carrier_on;
                     if (count == CNT_M) samp_m <= ~carrier_on;
                     if (count == CNT_SEC) begin
                        bit_a         <= samp_a;
                        bit_b         <= samp_b;
                        minute_marker <= samp_m & samp_a & samp_b;
                        sec_strobe    <= 1'b1;
                        state         <= WAIT_EDGE;
                     end
                  end
                  WAIT_EDGE: begin
                     // Drops earlier than 900 ms into the second are treated as noise.
                     if (fall && (count >= CNT_MIN)) begin
                        count <= 10'd0;
                        state <= MEASURE;
                     end else if (count == CNT_LOST) begin
                        lost_sync <= 1'b1;
                        state     <= HUNT;
                     end
                  end
                  default: state <= HUNT;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/msf_envelope_slicer.md
# msf_envelope_slicer

Downstream consumer of the IQ averager. It takes the 16-bit `average` stream and its `valid` strobe, tracks the carrier envelope with peak and floor detectors, and slices it into a carrier on/off decision with hysteresis. It then synchronises to the MSF second-start carrier drop and emits bit A, bit B and the minute marker once per second for the time-decode stage.

## Interface
- `AVG_PER_100MS`, default 10: number of `valid` strobes in 100 ms. Legal range 2..80, even values only.
- `DECAY_SHIFT`, default 8: peak decay and floor rise rate, applied as a right shift of the span.
- `HYST`, default 32: hysteresis half-width in amplitude LSBs.
- `MIN_SPAN`, default 64: minimum peak−floor span required to assert lock.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `average` in 16: unsigned averaged amplitude from the averager.
- `valid` in 1: one-cycle strobe qualifying `average`.
- `carrier_on` out 1: sliced carrier state, registered.
- `threshold` out 16: current slicing threshold.
- `locked` out 1: span ≥ `MIN_SPAN`.
- `sec_strobe` out 1: one-cycle pulse; `bit_a`, `bit_b` and `minute_marker` are valid in that cycle.
- `bit_a`, `bit_b`, `minute_marker` out 1 each: decoded second fields, held until the next `sec_strobe`.
- `lost_sync` out 1: one-cycle pulse on second timeout.

## Operation
- All state updates happen only on cycles with `valid`=1, except the one-cycle strobes.
- Reset values: `peak`=0, `floor`=0xFFFF, `threshold`=0, `carrier_on`=0, `locked`=0, `sec_strobe`=0, `bit_a`=0, `bit_b`=0, `minute_marker`=0, `lost_sync`=0, `count`=0, state HUNT.
- Envelope tracking, performed on each valid:
  - If `average` > `peak`: `peak`←`average`. Otherwise `peak`←`peak` − (`peak`>>`DECAY_SHIFT`).
  - If `average` < `floor`: `floor`←`average`. Otherwise, when `peak` > `floor`: `floor`←`floor` + ((`peak`−`floor`)>>`DECAY_SHIFT`).
- Span = `peak` − `floor`, computed in 17-bit arithmetic; span is 0 when `peak` ≤ `floor`.
- `threshold` = `floor` + span/2.
- `locked` = (span ≥ `MIN_SPAN`).
- Slicer, active only while `locked`:
  - `carrier_on`←1 when `average` > `threshold`+`HYST`.
  - `carrier_on`←0 when `average` < `threshold`−`HYST`.
  - Comparisons saturate at 0 and at 0xFFFF.
  - While unlocked, `carrier_on` is held at 0.
- Falling edge = `carrier_on` transitioning 1→0 on a valid cycle.
- `count` is 10 bits, increments on every valid, and saturates at 1023.
- Let N = `AVG_PER_100MS`.
- FSM:
  - HUNT: on a falling edge, `count`←0 and go to MEASURE.
  - MEASURE:
    - At `count`=3N/2, latch sample A = ~`carrier_on`.
    - At `count`=5N/2, latch sample B.
    - At `count`=9N/2, latch sample M.
    - At `count`=5N: register `bit_a`=A, `bit_b`=B, `minute_marker`=M&A&B; pulse `sec_strobe`; go to WAIT_EDGE.
    - Falling edges in MEASURE are ignored; the 01 pattern produces one at 200 ms.
  - WAIT_EDGE:
    - A falling edge with `count` ≥ 9N: `count`←0 and go to MEASURE.
    - A falling edge with `count` < 9N is ignored as a glitch.
    - At `count`=12N: pulse `lost_sync` and go to HUNT.
  - Loss of lock in any state: go to HUNT, no pulse.
- A reset mid-second aborts decode; no `sec_strobe` is issued for that second.

## Timing
- `carrier_on`, `threshold` and `locked` update one `clk` after the qualifying valid and use the pre-update `peak`/`floor`.
- Decode pipeline:
  - `sec_strobe` asserts one `clk` after the valid on which `count` reaches 5N.
  - It is exactly one cycle wide.
  - The output bits change in the same cycle as `sec_strobe`.
- `lost_sync` is one cycle wide, one `clk` after the valid reaching `count`=12N.
- `rst` has priority over `valid` in the same cycle.
- `valid` on consecutive cycles must be supported; the block applies no backpressure.

## Test plan
- Lock: reset, then alternate 20 valids of `average`=1080 and 20 of 108 (N=10) → `locked`=1; `threshold` within 594±8 after ≤3 cycles; `carrier_on` follows the input with no glitch.
- Bits 00: 10 low then 90 high valids per second, repeated 3 s → after the first edge, `sec_strobe` every 100 valids with `bit_a`=0, `bit_b`=0, `minute_marker`=0.
- Bits 10, 01, 11: 200 ms off; then 100 off/100 on/100 off; then 300 off → (A,B) = (1,0), (0,1), (1,1); `minute_marker`=0 in all three.
- Minute marker: 500 ms off, then 500 ms on → `bit_a`=1, `bit_b`=1, `minute_marker`=1.
- Glitch and timeout:
  - A 1-valid low glitch at `count`=60 in WAIT_EDGE → ignored, phase unchanged.
  - Holding the carrier high for 1.5 s → `lost_sync` at `count`=120, FSM in HUNT, no `sec_strobe`.
- Reset mid-second: assert `rst` at `count`=30 → all outputs at reset values next cycle; no `sec_strobe` for that second; relock after re-stimulus.
